led_scan_scheduler: RTL and testbench
=====================================

Name: led_scan_scheduler

Overview:
- Owns the 8x16 LED matrix drive outputs (xOut/yOut) and a double-banked 1-bit frame buffer.
- Scans the front bank pixel by pixel at a prescaled rate.
- Shares back-bank write access between two requesters (game logic = port 0, overlay/score = port 1) via a round-robin arbiter.
- Sequences back-bank clear and frame-boundary bank swaps so the displayed image never tears.

Parameters:
- COLS, 8, matrix columns; XW = clog2(COLS) = 3.
- ROWS, 16, matrix rows; YW = clog2(ROWS) = 4.
- SCAN_DIV, 10000, CLK cycles per pixel dwell. Minimum 1; benches use 2.

Ports:
- CLK  in  1  clock
- RSTn  in  1  reset, asynchronous, active-low
- req0  in  1  port-0 write request, level; held until granted
- x0 / y0 / d0  in  XW / YW / 1  port-0 pixel column / row / value
- gnt0  out  1  port-0 grant; write occurs on this cycle
- req1, x1, y1, d1, gnt1  same as port 0, for port 1
- clr_req  in  1  pulse: clear back bank
- clr_busy  out  1  high while clearing
- swap_req  in  1  pulse: request bank swap at next frame end
- swap_ack  out  1  1-cycle pulse after the swap is applied
- xOut  out  XW  scan column
- yOut  out  YW  scan row
- pix_on  out  1  front-bank bit at (xOut, yOut)

Behaviour:
- Reset values: xOut=0, yOut=ROWS-1, pix_on=0, gnt0/1=0, clr_busy=0, swap_ack=0, front bank index=0, both banks all-zero, RR pointer favours port 0, FSM=IDLE.
- Prescaler:
  - Counts 0..SCAN_DIV-1.
  - tick=1 in the cycle the count equals SCAN_DIV-1, then the count wraps to 0.
- Scan order on tick:
  - x increments. At x=COLS-1, x wraps to 0 and y decrements.
  - At y=0 with x=COLS-1, y wraps to ROWS-1.
  - frame_end = tick && x==COLS-1 && y==0.
- Output timing: xOut, yOut and pix_on are registered and change together on the edge that consumes the tick. pix_on is looked up from the front bank at the new address (zero-latency relative to xOut/yOut).
- Arbiter:
  - One back-bank write per cycle.
  - Only one request pending: it is granted.
  - Both pending: the port not granted last is granted.
  - Pointer updates only on an actual grant.
  - Grant is combinational from req (same cycle); the write lands at that edge.
  - x>=COLS or y>=ROWS: granted but discarded.
- FSM states:
  - IDLE:
    - clr_req -> CLEAR.
    - swap_req -> PEND.
    - Both in the same cycle -> CLEAR with swap latched.
  - CLEAR:
    - Zeroes one back-bank row per cycle, rows 0..ROWS-1, so ROWS cycles total.
    - clr_busy=1; gnt0=gnt1=0.
    - Exits to PEND if a swap is latched, else IDLE.
    - swap_req during CLEAR is latched.
  - PEND:
    - Writes still granted.
    - On frame_end: front index toggles, grants forced 0 that cycle -> ACK.
  - ACK: swap_ack=1 for one cycle -> IDLE.
- Other inputs during non-IDLE states:
  - swap_req in PEND/ACK is ignored (merged).
  - clr_req in CLEAR/PEND/ACK is ignored; clr_busy tells the requester to retry.
- Boundary cases:
  - frame_end during CLEAR: no swap; the swap waits for a later frame_end.
  - After a swap, pix_on from the next scan step shows the new front bank.
  - The front bank is never written.
  - RSTn asserted mid-clear or mid-pending: immediate return to reset values; the pending swap is lost.

Decomposition:
- Package led_scan_pkg:
  - COLS, ROWS, XW, YW constants.
  - FSM state enum {IDLE, CLEAR, PEND, ACK}.
- Sub-module rr_arbiter2: 2-input round-robin with last-grant pointer.
- Prescaler, scan counters, banks and FSM stay in the top.

Test Plan:
- Reset, SCAN_DIV=2, no writes:
  - xOut 0..7 each held 2 cycles, then y 15->14.
  - Full frame = 256 cycles; pix_on always 0.
- Port 0 writes (3,15,1), then swap_req:
  - swap_ack arrives one cycle after the frame_end at (7,0).
  - Next pass shows pix_on=1 only while xOut=3, yOut=15.
- req0 and req1 held high for 4 cycles, both first-requests after reset:
  - Grants alternate gnt0, gnt1, gnt0, gnt1.
  - Never both high in one cycle.
- clr_req with req0 held:
  - clr_busy high exactly 16 cycles, gnt0=0 throughout.
  - gnt0 rises the cycle after clr_busy falls.
  - Back bank reads all-zero after swap.
- swap_req twice before frame_end: exactly one swap_ack, one bank toggle.
- RSTn pulsed low while in PEND: outputs return to reset values; no swap_ack ever issued.

Source files
------------

// File: rtl/led_scan_pkg.sv
`default_nettype none
// ============================================================================
// led_scan_pkg
// Shared matrix geometry, scheduler state encoding and address range helper.
// Revision: 1.0
// ============================================================================
package led_scan_pkg;

   localparam int COLS = 8;
   localparam int ROWS = 16;
   localparam int XW   = $clog2(COLS);
   localparam int YW   = $clog2(ROWS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      PEND  = 2'd2,
      ACK   = 2'd3
   } state_t;

   function automatic logic in_matrix(input int x, input int y);
      return (x < COLS) && (y < ROWS);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// rr_arbiter2
// Two-port round-robin arbiter; combinational grant, last-grant pointer.
// Revision: 1.0
// ============================================================================
module rr_arbiter2 (
   input  logic CLK,
   input  logic RSTn,
   input  logic en,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   // Set when port 1 holds the most recent grant; reset value favours port 0.
   logic r_last1;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (en) begin
         if (req0 && (!req1 || r_last1))
            gnt0 = 1'b1;
         else if (req1)
            gnt1 = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn)
         r_last1 <= 1'b1;
      else if (gnt0)
         r_last1 <= 1'b0;
      else if (gnt1)
         r_last1 <= 1'b1;
   end

endmodule
`default_nettype wire

// File: rtl/led_scan_scheduler.sv
`default_nettype none
// ============================================================================
// led_scan_scheduler
// 8x16 LED scan with double-banked frame buffer, shared writes, tear-free swap.
// Revision: 1.0
// ============================================================================
module led_scan_scheduler
   import led_scan_pkg::*;
#(
   parameter int SCAN_DIV = 10000
) (
   input  logic          CLK,
   input  logic          RSTn,
   input  logic          req0,
   input  logic [XW-1:0] x0,
   input  logic [YW-1:0] y0,
   input  logic          d0,
   output logic          gnt0,
   input  logic          req1,
   input  logic [XW-1:0] x1,
   input  logic [YW-1:0] y1,
   input  logic          d1,
   output logic          gnt1,
   input  logic          clr_req,
   output logic          clr_busy,
   input  logic          swap_req,
   output logic          swap_ack,
   output logic [XW-1:0] xOut,
   output logic [YW-1:0] yOut,
   output logic          pix_on
);

   localparam int            c_dw      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [c_dw-1:0] c_div_max = c_dw'(SCAN_DIV - 1);
   localparam logic [XW-1:0] c_xmax    = XW'(COLS - 1);
   localparam logic [YW-1:0] c_ymax    = YW'(ROWS - 1);

   state_t            r_state;
   logic [c_dw-1:0]   r_div;
   logic              r_front;
   logic              r_swap_lat;
   logic [YW-1:0]     r_clr_row;
   logic [COLS-1:0]   r_bank [2][ROWS];

   logic              w_tick;
   logic              w_x_wrap;
   logic [XW-1:0]     w_x_nxt;
   logic [YW-1:0]     w_y_nxt;
   logic              w_frame_end;
   logic              w_swap_now;
   logic              w_front_nxt;
   logic              w_back;
   logic              w_gnt_en;
   logic              w_swap_seen;

   assign w_tick      = (r_div == c_div_max);
   assign w_x_wrap    = (xOut == c_xmax);
   assign w_x_nxt     = w_x_wrap ? '0 : xOut + XW'(1);
   assign w_y_nxt     = !w_x_wrap ? yOut : ((yOut == '0) ? c_ymax : yOut - YW'(1));
   assign w_frame_end = w_tick && w_x_wrap && (yOut == '0);
   assign w_swap_now  = (r_state == PEND) && w_frame_end;
   assign w_front_nxt = r_front ^ w_swap_now;
   assign w_back      = ~r_front;
   // No writes while clearing, nor on the edge where the banks trade places.
   assign w_gnt_en    = (r_state != CLEAR) && !w_swap_now;
   assign w_swap_seen = r_swap_lat || swap_req;

   rr_arbiter2 u_arb (
      .CLK  (CLK),
      .RSTn (RSTn),
      .en   (w_gnt_en),
      .req0 (req0),
      .req1 (req1),
      .gnt0 (gnt0),
      .gnt1 (gnt1)
   );

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn)
         r_div <= '0;
      else if (w_tick)
         r_div <= '0;
      else
         r_div <= r_div + c_dw'(1);
   end

   // pix_on reads the bank that will be front after this edge, so a swap
   // shows up on the very first pixel of the new frame.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         xOut   <= '0;
         yOut   <= c_ymax;
         pix_on <= 1'b0;
      end else if (w_tick) begin
         xOut   <= w_x_nxt;
         yOut   <= w_y_nxt;
         pix_on <= r_bank[w_front_nxt][w_y_nxt][w_x_nxt];
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int b = 0; b < 2; b++)
            for (int r = 0; r < ROWS; r++)
               r_bank[b][r] <= '0;
      end else if (r_state == CLEAR) begin
         r_bank[w_back][r_clr_row] <= '0;
      end else if (gnt0 && in_matrix(int'(x0), int'(y0))) begin
         r_bank[w_back][y0][x0] <= d0;
      end else if (gnt1 && in_matrix(int'(x1), int'(y1))) begin
         r_bank[w_back][y1][x1] <= d1;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state    <= IDLE;
         r_front    <= 1'b0;
         r_swap_lat <= 1'b0;
         r_clr_row  <= '0;
         clr_busy   <= 1'b0;
         swap_ack   <= 1'b0;
      end else begin
         swap_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (clr_req) begin
                  r_state    <= CLEAR;
                  clr_busy   <= 1'b1;
                  r_clr_row  <= '0;
                  r_swap_lat <= swap_req;
               end else if (swap_req) begin
                  r_state <= PEND;
               end
            end
            CLEAR: begin
               r_clr_row <= r_clr_row + YW'(1);
               if (r_clr_row == c_ymax) begin
                  clr_busy   <= 1'b0;
                  r_swap_lat <= 1'b0;
                  r_state    <= w_swap_seen ? PEND : IDLE;
               end else begin
                  r_swap_lat <= w_swap_seen;
               end
            end
            PEND: begin
               if (w_frame_end) begin
                  r_state  <= ACK;
                  r_front  <= ~r_front;
                  swap_ack <= 1'b1;
               end
            end
            ACK: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_led_scan_scheduler.sv
`default_nettype none
// ============================================================================
// tb_led_scan_scheduler
// Directed table/sequence checks plus random traffic against a frame-level model.
// Revision: 1.0
// ============================================================================
module tb_led_scan_scheduler;
   import led_scan_pkg::*;

   localparam int SD    = 2;
   localparam int NPIX  = COLS * ROWS;
   localparam int FRAME = NPIX * SD;

   logic          CLK = 1'b0;
   logic          RSTn = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0, d0 = 1'b0, d1 = 1'b0;
   logic [XW-1:0] x0 = '0, x1 = '0;
   logic [YW-1:0] y0 = '0, y1 = '0;
   logic          clr_req = 1'b0, swap_req = 1'b0;
   logic          gnt0, gnt1, clr_busy, swap_ack, pix_on;
   logic [XW-1:0] xOut;
   logic [YW-1:0] yOut;

   led_scan_scheduler #(.SCAN_DIV(SD)) dut (
      .CLK(CLK), .RSTn(RSTn),
      .req0(req0), .x0(x0), .y0(y0), .d0(d0), .gnt0(gnt0),
      .req1(req1), .x1(x1), .y1(y1), .d1(d1), .gnt1(gnt1),
      .clr_req(clr_req), .clr_busy(clr_busy),
      .swap_req(swap_req), .swap_ack(swap_ack),
      .xOut(xOut), .yOut(yOut), .pix_on(pix_on)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0, n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: pixel position follows from elapsed cycles, banks are bit arrays.
   int            m_c;
   bit            m_bank [2][ROWS][COLS];
   bit            m_front, m_lat, m_pend, m_ack, m_last1, m_fe;
   int            m_clr_left;
   logic          e_g0, e_g1, e_busy, e_ack, e_pix;
   logic [XW-1:0] e_x;
   logic [YW-1:0] e_y;

   task automatic model_reset();
      m_c = 0; m_front = 0; m_lat = 0; m_pend = 0; m_ack = 0; m_last1 = 1; m_clr_left = 0;
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) m_bank[b][r][c] = 0;
   endtask

   task automatic model_expect();
      int s, pos;
      bit allowed;
      s      = m_c / SD;
      pos    = s % NPIX;
      e_x    = XW'(pos % COLS);
      e_y    = YW'(ROWS - 1 - pos / COLS);
      m_fe   = ((m_c % SD) == SD - 1) && (pos == NPIX - 1);
      e_busy = (m_clr_left > 0);
      e_ack  = m_ack;
      e_pix  = m_bank[m_front][e_y][e_x];
      allowed = !e_busy && !(m_pend && m_fe);
      e_g0 = allowed && req0 && (!req1 || m_last1);
      e_g1 = allowed && req1 && !e_g0;
   endtask

   task automatic model_update();
      if (e_g0) begin m_bank[!m_front][y0][x0] = d0; m_last1 = 0; end
      if (e_g1) begin m_bank[!m_front][y1][x1] = d1; m_last1 = 1; end
      if (m_clr_left > 0) begin
         for (int c = 0; c < COLS; c++) m_bank[!m_front][ROWS - m_clr_left][c] = 0;
         m_lat = m_lat | swap_req;
         m_clr_left--;
         if (m_clr_left == 0 && m_lat) begin m_pend = 1; m_lat = 0; end
      end else if (m_ack) begin
         m_ack = 0;
      end else if (m_pend) begin
         if (m_fe) begin m_front = !m_front; m_pend = 0; m_ack = 1; end
      end else if (clr_req) begin
         m_clr_left = ROWS; m_lat = swap_req;
      end else if (swap_req) begin
         m_pend = 1;
      end
      m_c++;
   endtask

   int            n_ack, ack_c, pix_cnt;
   logic [XW-1:0] pix_x, last_x;
   logic [YW-1:0] pix_y, last_y;
   logic          last_g0, last_g1, last_busy;

   task automatic cyc();
      @(negedge CLK);
      model_expect();
      check("cycle", 32'({gnt0, gnt1, clr_busy, swap_ack, xOut, yOut, pix_on}),
                     32'({e_g0, e_g1, e_busy, e_ack, e_x, e_y, e_pix}));
      last_g0 = gnt0; last_g1 = gnt1; last_busy = clr_busy; last_x = xOut; last_y = yOut;
      if (swap_ack) begin n_ack++; ack_c = m_c; end
      if (pix_on) begin pix_cnt++; pix_x = xOut; pix_y = yOut; end
      @(posedge CLK);
      model_update();
      #1;
   endtask

   task automatic zero_inputs();
      req0 = 0; req1 = 0; d0 = 0; d1 = 0; x0 = '0; y0 = '0; x1 = '0; y1 = '0;
      clr_req = 0; swap_req = 0;
   endtask

   task automatic do_reset();
      RSTn = 0;
      zero_inputs();
      repeat (3) @(posedge CLK);
      #1;
      check("rst_vals", 32'({xOut, yOut, pix_on, gnt0, gnt1, clr_busy, swap_ack}),
                        32'({3'd0, 4'd15, 5'b0}));
      model_reset();
      RSTn = 1;
   endtask

   task automatic wait_ack(input int bound);
      for (int i = 0; i < bound && n_ack == 0; i++) cyc();
      check("ack_timeout", 32'(n_ack > 0), 32'd1);
   endtask

   typedef struct packed { logic r0, r1, g0, g1; } vec_t;
   vec_t tv [10];

   initial begin
      int busy_cnt, g_in_busy;
      bit seen, g_after;
      tv[0] = '{1'b1, 1'b1, 1'b1, 1'b0};
      tv[1] = '{1'b1, 1'b1, 1'b0, 1'b1};
      tv[2] = '{1'b1, 1'b1, 1'b1, 1'b0};
      tv[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
      tv[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      tv[5] = '{1'b0, 1'b0, 1'b0, 1'b0};
      tv[6] = '{1'b1, 1'b0, 1'b1, 1'b0};
      tv[7] = '{1'b1, 1'b1, 1'b0, 1'b1};
      tv[8] = '{1'b0, 1'b0, 1'b0, 1'b0};
      tv[9] = '{1'b1, 1'b1, 1'b1, 1'b0};
      n_ack = 0; pix_cnt = 0; ack_c = 0;

      // Idle scan: one full frame, blank display
      do_reset();
      for (int i = 0; i < FRAME; i++) begin
         cyc();
         if (i == SD * COLS - 1) check("scan_row_end", 32'({last_x, last_y}), 32'({3'd7, 4'd15}));
         if (i == SD * COLS)     check("scan_row_next", 32'({last_x, last_y}), 32'({3'd0, 4'd14}));
      end
      check("blank_frame", 32'(pix_cnt), 32'd0);

      // Single pixel then swap
      req0 = 1; x0 = 3; y0 = 15; d0 = 1;
      cyc();
      check("first_write_gnt", 32'({last_g0, last_g1}), 32'b10);
      zero_inputs(); swap_req = 1;
      cyc();
      swap_req = 0; n_ack = 0;
      wait_ack(2 * FRAME);
      check("ack_after_fe", 32'((ack_c - 1) % FRAME), 32'(FRAME - 1));
      pix_cnt = 0;
      repeat (FRAME) cyc();
      check("one_pixel_cnt", 32'(pix_cnt), 32'(SD));
      check("one_pixel_pos", 32'({pix_x, pix_y}), 32'({3'd3, 4'd15}));

      // Arbiter vector table from a fresh reset
      do_reset();
      foreach (tv[i]) begin
         req0 = tv[i].r0; req1 = tv[i].r1;
         x0 = XW'($urandom_range(0, COLS - 1)); y0 = YW'($urandom_range(0, ROWS - 1));
         x1 = XW'($urandom_range(0, COLS - 1)); y1 = YW'($urandom_range(0, ROWS - 1));
         d0 = 1; d1 = 1;
         cyc();
         check("arb_vec", 32'({last_g0, last_g1}), 32'({tv[i].g0, tv[i].g1}));
      end

      // Clear with port 0 held
      zero_inputs();
      req0 = 1; x0 = 5; y0 = 2; d0 = 0; clr_req = 1;
      cyc();
      clr_req = 0;
      busy_cnt = 0; g_in_busy = 0; seen = 0; g_after = 0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (last_busy) begin
            seen = 1; busy_cnt++;
            if (last_g0) g_in_busy++;
         end else if (seen) begin
            g_after = last_g0;
            break;
         end
      end
      check("clr_busy_len", 32'(busy_cnt), 32'(ROWS));
      check("clr_no_gnt", 32'(g_in_busy), 32'd0);
      check("gnt_after_clr", 32'(g_after), 32'd1);
      zero_inputs(); swap_req = 1;
      cyc();
      swap_req = 0; n_ack = 0;
      wait_ack(2 * FRAME);
      pix_cnt = 0;
      repeat (FRAME) cyc();
      check("cleared_frame", 32'(pix_cnt), 32'd0);

      // Two swap requests merge into one toggle
      req1 = 1; x1 = 6; y1 = 9; d1 = 1;
      cyc();
      zero_inputs(); n_ack = 0; swap_req = 1;
      cyc();
      swap_req = 0;
      repeat (5) cyc();
      swap_req = 1;
      cyc();
      swap_req = 0;
      wait_ack(2 * FRAME);
      pix_cnt = 0;
      repeat (FRAME) cyc();
      check("merged_swap_pix", 32'({pix_cnt[7:0], pix_x, pix_y}), 32'({8'(SD), 3'd6, 4'd9}));
      repeat (FRAME) cyc();
      check("merged_swap_acks", 32'(n_ack), 32'd1);

      // Reset asserted while a swap is pending
      swap_req = 1;
      cyc();
      swap_req = 0;
      repeat (10) cyc();
      @(negedge CLK);
      #2 RSTn = 0;
      #1 check("async_rst", 32'({xOut, yOut, pix_on, clr_busy, swap_ack}), 32'({3'd0, 4'd15, 3'b0}));
      do_reset();
      n_ack = 0;
      repeat (FRAME + 20) cyc();
      check("no_ack_after_rst", 32'(n_ack), 32'd0);

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         req0 = 1'($urandom_range(0, 1)); req1 = 1'($urandom_range(0, 1));
         x0 = XW'($urandom_range(0, COLS - 1)); y0 = YW'($urandom_range(0, ROWS - 1));
         x1 = XW'($urandom_range(0, COLS - 1)); y1 = YW'($urandom_range(0, ROWS - 1));
         d0 = 1'($urandom_range(0, 1)); d1 = 1'($urandom_range(0, 1));
         clr_req  = ($urandom_range(0, 299) == 0);
         swap_req = ($urandom_range(0, 79) == 0);
         cyc();
      end
      zero_inputs();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
